// File: rtl/stimulus_deserializer.sv
// stimulus_deserializer: consumer end of the stimulus stream interface.
// It samples the 4-bit stream on a fixed grid while data_valid is high and
// packs NIBBLES_PER_WORD nibbles MSB-first into a word. Completed words are
// buffered in a first-word-fall-through FIFO behind a valid/ready handshake.
// Optional build macro STIMULUS_DESERIALIZER_STATS_EN adds the sample_count and
// word_count statistics outputs.
module stimulus_deserializer #(
    parameter int SAMPLE_PERIOD    = 4,
    parameter int NIBBLES_PER_WORD = 4,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          data_valid,
    input  logic [3:0]                    stimulus_stream,
    output logic [4*NIBBLES_PER_WORD-1:0] word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_error
`ifdef STIMULUS_DESERIALIZER_STATS_EN
    ,
    output logic [15:0]                   sample_count,
    output logic [15:0]                   word_count
`endif
);

    localparam int WORD_W  = 4 * NIBBLES_PER_WORD;
    localparam int SHIFT_W = 4 * (NIBBLES_PER_WORD - 1);
    localparam int PHASE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int COUNT_W = $clog2(NIBBLES_PER_WORD);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SAMPLE_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(NIBBLES_PER_WORD - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
    localparam logic [ADDR_W:0]    PTR_ONE    = (ADDR_W + 1)'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state, state_next;
    logic [PHASE_W-1:0]  phase, phase_next;
    logic [COUNT_W-1:0]  count, count_next;
    logic [SHIFT_W-1:0]  shift, shift_next;
    logic                frame_error_next;
    logic                capture;
    logic                push;
    logic [WORD_W-1:0]   word_in;

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [ADDR_W:0]     wr_ptr, rd_ptr;
    logic                empty, full, pop, push_ok;

    // Only the previously captured nibbles are held; the newest nibble joins them on the final capture.
    always_comb begin
        state_next       = state;
        phase_next       = phase;
        count_next       = count;
        shift_next       = shift;
        frame_error_next = 1'b0;
        capture          = 1'b0;
        push             = 1'b0;
        word_in          = {shift, stimulus_stream};
        case (state)
            IDLE: begin
                if (data_valid) begin
                    capture    = 1'b1;
                    phase_next = (SAMPLE_PERIOD == 1) ? '0 : PHASE_ONE;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (data_valid) begin
                    capture    = (phase == '0);
                    phase_next = (phase == PHASE_LAST) ? '0 : phase + PHASE_ONE;
                end else begin
                    state_next = IDLE;
                    phase_next = '0;
                    if (count != '0) begin
                        count_next       = '0;
                        shift_next       = '0;
                        frame_error_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (capture) begin
            shift_next = word_in[SHIFT_W-1:0];
            if (count == COUNT_LAST) begin
                push       = 1'b1;
                count_next = '0;
            end else begin
                count_next = count + COUNT_ONE;
            end
        end
    end

    // Capture FSM, sample grid, nibble assembly and the registered frame_error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase       <= '0;
            count       <= '0;
            shift       <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            count       <= count_next;
            shift       <= shift_next;
            frame_error <= frame_error_next;
        end
    end

    // A push into a full FIFO still succeeds when the head is popped at the same edge.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop     = !empty && word_ready;
    assign push_ok = push && (!full || pop);

    // FIFO pointers and the sticky overflow flag for dropped words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Word storage; contents are only visible through the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= word_in;
        end
    end

    assign word_valid = !empty;
    assign word_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

`ifdef STIMULUS_DESERIALIZER_STATS_EN
    // Free-running statistics: captures and successfully stored words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_count <= '0;
            word_count   <= '0;
        end else begin
            if (capture) begin
                sample_count <= sample_count + 16'd1;
            end
            if (push_ok) begin
                word_count <= word_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stimulus_deserializer.sv
// Directed self-checking bench for stimulus_deserializer with default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_stimulus_deserializer;

    localparam int SP = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [3:0]  stimulus_stream = 4'h0;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        word_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        frame_error;
`ifdef STIMULUS_DESERIALIZER_STATS_EN
    logic [15:0] sample_count;
    logic [15:0] word_count;
`endif

    int checks = 0;
    int failures = 0;

    stimulus_deserializer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .data_valid      (data_valid),
        .stimulus_stream (stimulus_stream),
        .word_data       (word_data),
        .word_valid      (word_valid),
        .word_ready      (word_ready),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .frame_error     (frame_error)
`ifdef STIMULUS_DESERIALIZER_STATS_EN
        ,
        .sample_count    (sample_count),
        .word_count      (word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input logic [3:0] nib, input logic rdy);
        data_valid      = dv;
        stimulus_stream = nib;
        word_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendNibble(input logic [3:0] nib, input logic rdy);
        applyStimulus(1'b1, nib, rdy);
        repeat (SP) step();
    endtask

    task automatic drainWord(input string tag, input logic [15:0] expected);
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput({tag, " valid"}, word_valid, 1);
        checkOutput({tag, " data"}, word_data, expected);
        step();
    endtask

    initial begin
        logic [15:0] seq_words [4];
        logic [3:0]  tail_nibs [4];
        seq_words = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        tail_nibs = '{4'h9, 4'h8, 4'h7, 4'h6};

        // Reset state
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        step();
        checkOutput("reset word_valid", word_valid, 0);
        checkOutput("reset word_data", word_data, 0);
        checkOutput("reset fifo_level", fifo_level, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset frame_error", frame_error, 0);
        reset_n = 1'b1;
        step();

        // Single word 0x1234 with ready held high
        $display("[TB] single word");
        for (int c = 0; c < 16; c++) begin
            applyStimulus(1'b1, 4'(c / 4 + 1), 1'b1);
            step();
            if (c == 12) begin
                checkOutput("t1 valid at push", word_valid, 1);
                checkOutput("t1 data", word_data, 16'h1234);
                checkOutput("t1 level at push", fifo_level, 1);
            end else begin
                checkOutput("t1 valid idle", word_valid, 0);
            end
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t1 no frame_error", frame_error, 0);
        checkOutput("t1 level end", fifo_level, 0);

        // Fill FIFO with four words, then drain in order
        $display("[TB] fill and drain");
        for (int k = 0; k < 16; k++) sendNibble(4'(k), 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t2 level full", fifo_level, 4);
        checkOutput("t2 overflow", overflow, 0);
        for (int i = 0; i < 4; i++) drainWord("t2 pop", seq_words[i]);
        checkOutput("t2 empty valid", word_valid, 0);
        checkOutput("t2 empty level", fifo_level, 0);
        checkOutput("t2 overflow after", overflow, 0);

        // Fifth word dropped, overflow sticky
        $display("[TB] overflow");
        for (int k = 0; k < 20; k++) sendNibble(4'(k), 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t3 overflow set", overflow, 1);
        checkOutput("t3 level", fifo_level, 4);
        repeat (3) step();
        checkOutput("t3 overflow sticky", overflow, 1);
        for (int i = 0; i < 4; i++) drainWord("t3 pop", seq_words[i]);
        checkOutput("t3 empty valid", word_valid, 0);
        checkOutput("t3 overflow after drain", overflow, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t3 overflow cleared by reset", overflow, 0);
        step();
        reset_n = 1'b1;
        step();

        // Push into full FIFO while popping
        $display("[TB] full push with pop");
        for (int k = 0; k < 16; k++) sendNibble(4'(k), 1'b0);
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < SP; c++) begin
                applyStimulus(1'b1, tail_nibs[j], (j == 3 && c == 0));
                step();
                if (j == 3 && c == 0) begin
                    checkOutput("t4 level at push+pop", fifo_level, 4);
                    checkOutput("t4 no overflow", overflow, 0);
                end
            end
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t4 level after", fifo_level, 4);
        drainWord("t4 pop1", 16'h4567);
        drainWord("t4 pop2", 16'h89AB);
        drainWord("t4 pop3", 16'hCDEF);
        drainWord("t4 pop4", 16'h9876);
        checkOutput("t4 empty valid", word_valid, 0);
        checkOutput("t4 overflow end", overflow, 0);

        // Partial frame A,B discarded with one frame_error pulse
        $display("[TB] frame error");
        sendNibble(4'hA, 1'b0);
        sendNibble(4'hB, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("t5 frame_error before", frame_error, 0);
        step();
        checkOutput("t5 frame_error pulse", frame_error, 1);
        step();
        checkOutput("t5 frame_error cleared", frame_error, 0);
        checkOutput("t5 level", fifo_level, 0);
        sendNibble(4'h5, 1'b0);
        sendNibble(4'h6, 1'b0);
        sendNibble(4'h7, 1'b0);
        sendNibble(4'h8, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t5 level next frame", fifo_level, 1);
        checkOutput("t5 data next frame", word_data, 16'h5678);
        checkOutput("t5 no frame_error", frame_error, 0);
        drainWord("t5 pop", 16'h5678);
        checkOutput("t5 level end", fifo_level, 0);

        // Reset mid-word with two words queued
        $display("[TB] reset mid-frame");
        for (int k = 0; k < 9; k++) sendNibble(4'(k), 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0);
        step();
        checkOutput("t6 level before reset", fifo_level, 2);
        reset_n = 1'b0;
        #1;
        checkOutput("t6 reset word_valid", word_valid, 0);
        checkOutput("t6 reset word_data", word_data, 0);
        checkOutput("t6 reset fifo_level", fifo_level, 0);
        checkOutput("t6 reset overflow", overflow, 0);
        checkOutput("t6 reset frame_error", frame_error, 0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        checkOutput("t6 no frame_error after reset", frame_error, 0);
        sendNibble(4'h3, 1'b0);
        sendNibble(4'hC, 1'b0);
        sendNibble(4'h5, 1'b0);
        sendNibble(4'hA, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        step();
        checkOutput("t6 level fresh", fifo_level, 1);
        drainWord("t6 pop", 16'h3C5A);
        checkOutput("t6 empty valid", word_valid, 0);
        checkOutput("t6 level end", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stimulus_deserializer.md
Name: stimulus_deserializer

Overview:
- Synthesizable consumer end of the stimulus stream interface: a level `data_valid` plus a 4-bit `stimulus_stream`, with one new sample every SAMPLE_PERIOD clocks while valid is high.
- Captures samples on the sample grid and packs NIBBLES_PER_WORD nibbles, MSB-first, into a word.
- Buffers completed words in a small first-word-fall-through FIFO and presents them on a valid/ready output handshake.
- Sits between the stimulus generator and the lab datapath under test.

Parameters:
- SAMPLE_PERIOD, 4: clocks between successive samples while `data_valid` is high; must be ≥ 1.
- NIBBLES_PER_WORD, 4: nibbles per output word; must be ≥ 2.
- FIFO_DEPTH, 4: word FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_valid  in  1  level; high while `stimulus_stream` carries valid samples.
- stimulus_stream  in  4  sample nibble.
- word_data  out  4*NIBBLES_PER_WORD  FIFO head word; first nibble received is in the MSBs.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when high together with `word_valid`.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored words.
- overflow  out  1  sticky; a completed word was dropped.
- frame_error  out  1  one-cycle pulse; a partial word was discarded.

Behaviour:
- Reset (async, `reset_n` low): FSM = IDLE, phase and nibble counters = 0, shift register = 0, FIFO emptied.
  - Outputs: `word_valid`=0, `word_data`=0, `fifo_level`=0, `overflow`=0, `frame_error`=0.
  - Reset mid-word or mid-FIFO discards everything; no `frame_error` is raised for it.
- FSM IDLE:
  - On a clock with `data_valid`=1, capture the nibble, set phase = 1 (wrapping to 0 when SAMPLE_PERIOD = 1), go to RUN.
- FSM RUN, `data_valid`=1:
  - Phase counts 0..SAMPLE_PERIOD-1 and wraps.
  - A capture occurs on each cycle where phase = 0.
  - Captures therefore land on the first valid cycle and then every SAMPLE_PERIOD clocks.
- FSM RUN, `data_valid`=0:
  - Return to IDLE and clear phase.
  - If the nibble count is non-zero: clear the count and shift register, and pulse `frame_error` for exactly 1 cycle, in the cycle after the falling clock.
- Capture:
  - Each capture shifts the nibble into the shift register's LSBs and increments the nibble count.
  - The capture that makes the count equal NIBBLES_PER_WORD pushes the assembled word (prior nibbles plus the current nibble) at that same edge and clears the count.
  - Latency: `word_valid` is high the cycle after the final capture edge when the FIFO was empty.
- FIFO:
  - Pop occurs when `word_valid` and `word_ready` are both high.
  - `word_data` = head entry when not empty, else 0.
  - `fifo_level` updates by the net result of push and pop each clock.
- Full, push without pop: the word is dropped, `overflow` is set and stays high until reset; the FIFO is unchanged.
- Full, push with pop in the same cycle: both succeed; no overflow; level unchanged.
- Empty, push with `word_ready` high: no same-cycle bypass; the word is visible the next cycle.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived with an extra pointer MSB.
- `word_ready` is ignored while `word_valid`=0.

Optional Feature:
- Macro: STIMULUS_DESERIALIZER_STATS_EN.
- When defined, adds two outputs, both reset to 0, free-running and wrapping at 0xFFFF:
  - `sample_count` (16 bits): counts captures.
  - `word_count` (16 bits): counts successful FIFO pushes (dropped words excluded).
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults; `data_valid` high for 16 clocks with nibbles 1,2,3,4 each held 4 clocks, `word_ready`=1 → exactly one word 0x1234, `word_valid` high for 1 cycle the clock after the 4th capture, `fifo_level` returns to 0.
- `word_ready`=0; stream 16 nibbles 0..F → `fifo_level`=4; then raise `word_ready` → pops 0x0123, 0x4567, 0x89AB, 0xCDEF in order; `overflow`=0.
- `word_ready`=0; stream 20 nibbles → 5th word dropped, `overflow`=1 and sticky; `fifo_level`=4; contents are the first four words.
- FIFO full and `word_ready`=1 during the cycle the 5th word completes → no overflow, `fifo_level` stays 4, 5th word is delivered last.
- Stream nibbles A,B then drop `data_valid` → single `frame_error` pulse; next frame 5,6,7,8 → 0x5678 with no leftover A/B.
- Assert `reset_n` low after 2 captures and with 2 words queued → all outputs 0 immediately; after release, a fresh 4-nibble frame produces the correct single word.
